// File: rtl/calc_entry_ctrl.sv
// Calculator key-entry sequencer: builds two decimal operands and an operator
// from numpad events, launches the ALU and holds the value shown on the display.
module calc_entry_ctrl #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           key,
    input  logic                 alu_done,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_err,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [1:0]           opcode,
    output logic                 alu_start,
    output logic [2*WIDTH-1:0]   display,
    output logic                 disp_err,
    output logic [1:0]           state
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]      CNT_MAX     = CW'(DIGITS);
    localparam logic [2*WIDTH-1:0] OPERAND_MAX = (2*WIDTH)'(10**DIGITS - 1);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_ALU = 2'd2,
        SHOW     = 2'd3
    } state_t;

    state_t cur, nxt;

    logic [CW-1:0]        cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic [WIDTH-1:0]     op_a_nxt, op_b_nxt;
    logic [1:0]           opcode_nxt;
    logic [2*WIDTH-1:0]   display_nxt;
    logic                 disp_err_nxt, alu_start_nxt, clear;

    logic                 is_digit, is_op, is_eq, is_clr;
    logic [3:0]           digit;

    function automatic logic [WIDTH-1:0] accum(input logic [WIDTH-1:0] v, input logic [3:0] d);
        return (v << 3) + (v << 1) + WIDTH'(d);
    endfunction

    // Leading zeros never consume a digit slot.
    function automatic logic accept(input logic [CW-1:0] cnt, input logic [WIDTH-1:0] v,
                                    input logic [3:0] d);
        return (cnt != CNT_MAX) && !((v == '0) && (d == 4'd0));
    endfunction

    // Keypad is wired column-major: 1 4 7 0 / 2 5 8 F / 3 6 9 E / A B C D.
    always_comb begin
        is_digit = 1'b0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        is_clr   = 1'b0;
        digit    = 4'd0;
        if (key[4]) begin
            case (key[3:0])
                4'd0:  begin is_digit = 1'b1; digit = 4'd1; end
                4'd1:  begin is_digit = 1'b1; digit = 4'd4; end
                4'd2:  begin is_digit = 1'b1; digit = 4'd7; end
                4'd3:  begin is_digit = 1'b1; digit = 4'd0; end
                4'd4:  begin is_digit = 1'b1; digit = 4'd2; end
                4'd5:  begin is_digit = 1'b1; digit = 4'd5; end
                4'd6:  begin is_digit = 1'b1; digit = 4'd8; end
                4'd7:  is_clr = 1'b1;
                4'd8:  begin is_digit = 1'b1; digit = 4'd3; end
                4'd9:  begin is_digit = 1'b1; digit = 4'd6; end
                4'd10: begin is_digit = 1'b1; digit = 4'd9; end
                4'd11: is_eq = 1'b1;
                default: is_op = 1'b1;
            endcase
        end
    end

    always_comb begin
        nxt           = cur;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        cnt_a_nxt     = cnt_a;
        cnt_b_nxt     = cnt_b;
        opcode_nxt    = opcode;
        display_nxt   = display;
        disp_err_nxt  = disp_err;
        alu_start_nxt = 1'b0;
        clear         = 1'b0;

        case (cur)
            ENTER_A: begin
                if (is_digit) begin
                    if (accept(cnt_a, op_a, digit)) begin
                        op_a_nxt    = accum(op_a, digit);
                        cnt_a_nxt   = cnt_a + 1'b1;
                        display_nxt = (2*WIDTH)'(accum(op_a, digit));
                    end
                end else if (is_op) begin
                    opcode_nxt  = key[1:0];
                    op_b_nxt    = '0;
                    cnt_b_nxt   = '0;
                    display_nxt = '0;
                    nxt         = ENTER_B;
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            ENTER_B: begin
                if (is_digit) begin
                    if (accept(cnt_b, op_b, digit)) begin
                        op_b_nxt    = accum(op_b, digit);
                        cnt_b_nxt   = cnt_b + 1'b1;
                        display_nxt = (2*WIDTH)'(accum(op_b, digit));
                    end
                end else if (is_op) begin
                    if (cnt_b == '0) opcode_nxt = key[1:0];
                end else if (is_eq) begin
                    if (cnt_b != '0) begin
                        alu_start_nxt = 1'b1;
                        nxt           = WAIT_ALU;
                    end
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            WAIT_ALU: begin
                if (alu_done) begin
                    display_nxt  = alu_result;
                    disp_err_nxt = alu_err;
                    nxt          = SHOW;
                end
            end
            SHOW: begin
                if (is_digit) begin
                    op_a_nxt     = WIDTH'(digit);
                    cnt_a_nxt    = CW'(digit != 4'd0);
                    op_b_nxt     = '0;
                    disp_err_nxt = 1'b0;
                    display_nxt  = (2*WIDTH)'(digit);
                    nxt          = ENTER_A;
                end else if (is_op) begin
                    // Chain only when the shown result fits back into an operand.
                    if (!disp_err && (display <= OPERAND_MAX)) begin
                        op_a_nxt     = display[WIDTH-1:0];
                        cnt_a_nxt    = CNT_MAX;
                        opcode_nxt   = key[1:0];
                        op_b_nxt     = '0;
                        cnt_b_nxt    = '0;
                        disp_err_nxt = 1'b0;
                        display_nxt  = '0;
                        nxt          = ENTER_B;
                    end
                end else if (is_clr) begin
                    clear = 1'b1;
                end
            end
            default: nxt = ENTER_A;
        endcase

        if (clear) begin
            nxt          = ENTER_A;
            op_a_nxt     = '0;
            op_b_nxt     = '0;
            cnt_a_nxt    = '0;
            cnt_b_nxt    = '0;
            opcode_nxt   = 2'd0;
            display_nxt  = '0;
            disp_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur <= ENTER_A;
        else       cur <= nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            opcode    <= 2'd0;
            display   <= '0;
            disp_err  <= 1'b0;
            alu_start <= 1'b0;
        end else begin
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            cnt_a     <= cnt_a_nxt;
            cnt_b     <= cnt_b_nxt;
            opcode    <= opcode_nxt;
            display   <= display_nxt;
            disp_err  <= disp_err_nxt;
            alu_start <= alu_start_nxt;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: vector table, directed corner sequences and a
// randomized run against a digit-queue reference model.
module tb_calc_entry_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  key;
    logic        alu_done;
    logic [27:0] alu_result;
    logic        alu_err;
    logic [13:0] op_a, op_b;
    logic [1:0]  opcode;
    logic        alu_start;
    logic [27:0] display;
    logic        disp_err;
    logic [1:0]  state;

    calc_entry_ctrl #(.DIGITS(4), .WIDTH(14)) dut (
        .clock(clock), .reset(reset), .key(key), .alu_done(alu_done),
        .alu_result(alu_result), .alu_err(alu_err), .op_a(op_a), .op_b(op_b),
        .opcode(opcode), .alu_start(alu_start), .display(display),
        .disp_err(disp_err), .state(state)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: operands kept as lists of entered decimal digits.
    int     m_st;
    int     qa[$];
    int     qb[$];
    int     m_opc;
    longint m_disp;
    bit     m_err;
    bit     m_start;

    function automatic longint val_a();
        longint v = 0;
        foreach (qa[i]) v = v * 10 + qa[i];
        return v;
    endfunction

    function automatic longint val_b();
        longint v = 0;
        foreach (qb[i]) v = v * 10 + qb[i];
        return v;
    endfunction

    // Keypad legend: >=0 digit, -1 clear, -2 equals, -3 operator.
    function automatic int legend(int c);
        case (c)
            0: return 1;   1: return 4;   2: return 7;   3: return 0;
            4: return 2;   5: return 5;   6: return 8;   7: return -1;
            8: return 3;   9: return 6;  10: return 9;  11: return -2;
            default: return -3;
        endcase
    endfunction

    function automatic void model_reset();
        m_st = 0; qa.delete(); qb.delete(); m_opc = 0; m_disp = 0; m_err = 0; m_start = 0;
    endfunction

    function automatic void model_step(int k, bit d, longint r, bit e);
        int lg = 0;
        bit pressed = (k >= 16);
        longint v;
        if (pressed) lg = legend(k - 16);
        m_start = 0;
        case (m_st)
            0, 1: begin
                if (pressed && lg >= 0) begin
                    if (m_st == 0) begin
                        if (qa.size() < 4 && !(qa.size() == 0 && lg == 0)) qa.push_back(lg);
                        m_disp = val_a();
                    end else begin
                        if (qb.size() < 4 && !(qb.size() == 0 && lg == 0)) qb.push_back(lg);
                        m_disp = val_b();
                    end
                end else if (pressed && lg == -3) begin
                    if (m_st == 0) begin
                        m_opc = k - 28; qb.delete(); m_disp = 0; m_st = 1;
                    end else if (qb.size() == 0) begin
                        m_opc = k - 28;
                    end
                end else if (pressed && lg == -2) begin
                    if (m_st == 1 && qb.size() > 0) begin
                        m_start = 1; m_st = 2;
                    end
                end else if (pressed && lg == -1) begin
                    model_reset();
                end
            end
            2: begin
                if (d) begin
                    m_disp = r; m_err = e; m_st = 3;
                end
            end
            default: begin
                if (pressed && lg >= 0) begin
                    qa.delete();
                    if (lg != 0) qa.push_back(lg);
                    qb.delete(); m_err = 0; m_disp = lg; m_st = 0;
                end else if (pressed && lg == -3) begin
                    if (!m_err && m_disp <= 9999) begin
                        qa.delete(); v = m_disp;
                        for (int i = 0; i < 4; i++) begin
                            qa.push_front(int'(v % 10)); v = v / 10;
                        end
                        m_opc = k - 28; qb.delete(); m_err = 0; m_disp = 0; m_st = 1;
                    end
                end else if (pressed && lg == -1) begin
                    model_reset();
                end
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        check("state", 64'(state), 64'(m_st));
        check("op_a", 64'(op_a), 64'(val_a()));
        check("op_b", 64'(op_b), 64'(val_b()));
        check("opcode", 64'(opcode), 64'(m_opc));
        check("alu_start", 64'(alu_start), 64'(m_start));
        check("display", 64'(display), 64'(m_disp));
        check("disp_err", 64'(disp_err), 64'(m_err));
    endtask

    task automatic apply(input int k, input bit d, input longint r, input bit e);
        @(negedge clock);
        key = 5'(k); alu_done = d; alu_result = r[27:0]; alu_err = e;
        model_step(k, d, r, e);
        @(posedge clock);
        #1;
        key = 5'd0; alu_done = 1'b0;
        cyc++;
        compare_model();
    endtask

    task automatic keys(input int k0, input int k1, input int k2, input int k3);
        if (k0 >= 0) apply(k0, 0, 0, 0);
        if (k1 >= 0) apply(k1, 0, 0, 0);
        if (k2 >= 0) apply(k2, 0, 0, 0);
        if (k3 >= 0) apply(k3, 0, 0, 0);
    endtask

    typedef struct {
        int     k;
        bit     done;
        longint res;
        int     st;
        longint a;
        longint b;
        int     opc;
        bit     start;
        longint disp;
    } vec_t;

    vec_t vt[8];
    int   wait_cnt;
    int   rk;
    bit   rd;
    longint rr;
    bit   re;

    initial begin
        vt[0] = '{16, 0, 0,  0, 1,  0, 0, 0, 1};
        vt[1] = '{20, 0, 0,  0, 12, 0, 0, 0, 12};
        vt[2] = '{28, 0, 0,  1, 12, 0, 0, 0, 0};
        vt[3] = '{24, 0, 0,  1, 12, 3, 0, 0, 3};
        vt[4] = '{27, 0, 0,  2, 12, 3, 0, 1, 3};
        vt[5] = '{0,  0, 0,  2, 12, 3, 0, 0, 3};
        vt[6] = '{0,  1, 15, 3, 12, 3, 0, 0, 15};
        vt[7] = '{0,  0, 0,  3, 12, 3, 0, 0, 15};

        reset = 1'b1; key = 5'd0; alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        model_reset();
        #35;
        compare_model();
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply(vt[i].k, vt[i].done, vt[i].res, 1'b0);
            check("tbl_state", 64'(state), 64'(vt[i].st));
            check("tbl_op_a", 64'(op_a), 64'(vt[i].a));
            check("tbl_op_b", 64'(op_b), 64'(vt[i].b));
            check("tbl_opcode", 64'(opcode), 64'(vt[i].opc));
            check("tbl_alu_start", 64'(alu_start), 64'(vt[i].start));
            check("tbl_display", 64'(display), 64'(vt[i].disp));
        end

        // Leading zeros are free and the fifth digit is dropped.
        keys(23, 19, 19, 21);
        keys(16, 20, 24, 17);
        check("sat_op_a", 64'(op_a), 64'd5123);
        check("sat_display", 64'(display), 64'd5123);

        // Operator replacement only before any B digit.
        keys(31, 30, 18, 28);
        check("oprep_opcode", 64'(opcode), 64'd2);
        check("oprep_op_b", 64'(op_b), 64'd7);
        keys(23, 16, 28, 19);
        apply(27, 0, 0, 0);
        check("eq_noB_start", 64'(alu_start), 64'd0);
        check("eq_noB_state", 64'(state), 64'd1);

        // Chaining, overflow and error display.
        keys(23, 26, 26, 26);
        keys(26, 28, 16, 27);
        apply(0, 1, 9999, 0);
        apply(28, 0, 0, 0);
        check("chain_state", 64'(state), 64'd1);
        check("chain_op_a", 64'(op_a), 64'd9999);
        keys(16, 27, -1, -1);
        apply(0, 1, 10000, 0);
        apply(28, 0, 0, 0);
        check("big_state", 64'(state), 64'd3);
        check("big_display", 64'(display), 64'd10000);
        apply(22, 0, 0, 0);
        check("big_digit_op_a", 64'(op_a), 64'd8);
        check("big_digit_err", 64'(disp_err), 64'd0);
        keys(28, 16, 27, -1);
        apply(0, 1, 5, 1);
        apply(29, 0, 0, 0);
        check("err_state", 64'(state), 64'd3);
        check("err_flag", 64'(disp_err), 64'd1);

        // Clear key coinciding with alu_done is dropped.
        keys(23, 16, 28, 16);
        apply(27, 0, 0, 0);
        apply(23, 1, 2, 0);
        check("fdone_state", 64'(state), 64'd3);
        check("fdone_display", 64'(display), 64'd2);

        // Reset while waiting on the ALU aborts the calculation.
        keys(23, 16, 28, 16);
        apply(27, 0, 0, 0);
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset_state", 64'(state), 64'd0);
        compare_model();
        @(negedge clock);
        reset = 1'b0;
        apply(0, 1, 2, 0);
        check("late_done_state", 64'(state), 64'd0);
        check("late_done_display", 64'(display), 64'd0);

        wait_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rk = $urandom % 100;
            if (rk < 35) rk = 0;
            else if (rk < 40) rk = int'($urandom_range(1, 15));
            else begin
                rk = int'($urandom_range(16, 31));
                if (rk == 23 && ($urandom % 4) != 0) rk = 0;
            end
            rd = 1'b0;
            if (m_st == 2) begin
                if (wait_cnt <= 1) rd = 1'b1;
                else wait_cnt--;
            end else begin
                rd = (($urandom % 20) == 0);
            end
            rr = (($urandom % 3) == 0) ? longint'($urandom_range(10000, 28'hFFFFFFF))
                                       : longint'($urandom_range(0, 9999));
            re = (($urandom % 6) == 0);
            apply(rk, rd, rr, re);
            if (m_start) wait_cnt = int'($urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Key-entry sequencer for the calculator. It consumes the numpad's one-cycle key-change codes and builds two decimal operands and an operator.
- It launches the external ALU through a start/done handshake and holds the value to be shown on the display.
- It sits between the numpad scanner and the ALU/display path. The whole block runs on the single system clock.

Parameters:
- DIGITS, 4, maximum decimal digits per operand.
- WIDTH, 14, operand width in bits. It must hold 10^DIGITS-1.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- key  in  5  numpad event code. 0 = no event; 16..31 = key pressed; 1..15 are ignored.
- alu_done  in  1  one-cycle pulse from the ALU: result is valid.
- alu_result  in  2*WIDTH  ALU result, unsigned.
- alu_err  in  1  ALU error flag (e.g. divide by zero), sampled with alu_done.
- op_a  out  WIDTH  operand A.
- op_b  out  WIDTH  operand B.
- opcode  out  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  one-cycle launch pulse.
- display  out  2*WIDTH  value to show.
- disp_err  out  1  display shows the error indication.
- state  out  2  FSM state: 0 ENTER_A, 1 ENTER_B, 2 WAIT_ALU, 3 SHOW.

Behaviour:
- Key decode:
  - 16=1, 17=4, 18=7, 19=0, 20=2, 21=5, 22=8, 24=3, 25=6, 26=9.
  - 28=A (add), 29=B (sub), 30=C (mul), 31=D (div).
  - 27=E (equals), 23=F (clear).
- Reset (asynchronous): state=ENTER_A; op_a, op_b, opcode, display, disp_err, alu_start and both digit counters = 0.
- At most one key event is processed per clock.
- Digit accumulation (ENTER_A into op_a, ENTER_B into op_b): operand <= operand*10 + d, counter++.
  - A digit arriving when counter==DIGITS is ignored.
  - A 0 digit arriving while the operand is 0 changes nothing and does not increment the counter (leading zeros are free).
- display tracks the operand being edited: op_a in ENTER_A, op_b in ENTER_B, zero-extended.
- ENTER_A:
  - digit: accumulate.
  - operator: latch opcode; op_b=0; B counter=0; go to ENTER_B.
  - E: ignored.
  - F: clear everything to reset values.
- ENTER_B:
  - digit: accumulate.
  - operator: replaces opcode only if B counter==0; otherwise ignored.
  - E with B counter==0: ignored.
  - E with B counter>0: alu_start=1 for exactly one cycle; go to WAIT_ALU.
  - F: clear everything.
- WAIT_ALU:
  - All keys, including F, are ignored.
  - op_a, op_b and opcode are held stable.
  - alu_done is ignored in every other state.
  - alu_done arrives no earlier than the cycle after alu_start.
  - On alu_done: display<=alu_result, disp_err<=alu_err, go to SHOW.
  - If a key event and alu_done occur in the same cycle, done is processed and the key is dropped.
- SHOW:
  - digit: op_a=d; A counter=(d!=0); op_b=0; disp_err=0; go to ENTER_A.
  - operator, when !disp_err and display <= 10^DIGITS-1: op_a<=display[WIDTH-1:0]; A counter=DIGITS; latch opcode; op_b=0; B counter=0; disp_err=0; go to ENTER_B (chained calculation).
  - operator otherwise: ignored.
  - E: ignored.
  - F: clear everything.
- alu_start is registered. It is never asserted outside the cycle of the E transition.
- Reset in WAIT_ALU aborts the calculation. A later alu_done is ignored because state is ENTER_A.
- All arithmetic is unsigned. The multiply-by-10 accumulate cannot overflow, given the DIGITS cap and the WIDTH rule.

Test Plan:
- Reset, then keys 1,2,A,3,E (codes 16,20,28,24,27):
  - alu_start pulses once with op_a=12, op_b=3, opcode=0.
  - Drive alu_done with result 15: display=15, state=SHOW.
- Keys 0,0,5 then 1,2,3,4 in ENTER_A: op_a=5123. The counter saturates at 4, so the final digit 4 is ignored.
- In ENTER_B:
  - Keys D, then C: opcode=2.
  - Then digit 7, then key A: opcode stays 2.
  - E in ENTER_B with no B digits: no alu_start.
- Chaining and error:
  - SHOW with display=9999: key A moves op_a=9999 into ENTER_B.
  - SHOW with display=10000, or with alu_err=1: key A is ignored. Digit 8 then gives op_a=8, disp_err=0.
- Key F and alu_done coincide in WAIT_ALU: the result is captured and state=SHOW (F dropped).
- Assert reset during WAIT_ALU, then pulse alu_done: state stays ENTER_A and display stays 0.
